// File: rtl/data_sram_pipe_pkg.sv
// Shared constants for the pipelined data memory: derived index widths,
// response-record field layout and the supported read-latency range.
package data_sram_pipe_pkg;

   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 3;

   // Response record packs {rdata, err, wen} with wen in the LSB.
   localparam int unsigned RSP_WEN_POS  = 0;
   localparam int unsigned RSP_ERR_POS  = 1;
   localparam int unsigned RSP_DATA_POS = 2;
   localparam int unsigned RSP_META_W   = 2;

   function automatic int unsigned lg_b(input int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

   function automatic int unsigned lg_d(input int unsigned depth);
      return $clog2(depth);
   endfunction

   function automatic int unsigned clamp_lat(input int unsigned lat);
      if (lat < RD_LAT_MIN) return RD_LAT_MIN;
      if (lat > RD_LAT_MAX) return RD_LAT_MAX;
      return lat;
   endfunction

endpackage

// File: rtl/data_sram_pipe_rsp_fifo.sv
// In-order response FIFO; occupancy count decides full/empty so any depth works.
module rsp_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_i,
   input  logic [W-1:0]                 wdata_i,
   input  logic                         pop_i,
   output logic [W-1:0]                 rdata_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic          do_push, do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_push = push_i && (cnt_q != CW'(DEPTH));
   assign do_pop  = pop_i && (cnt_q != '0);
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = cnt_q;

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= nxt(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= nxt(rd_ptr_q);
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/data_sram_pipe.sv
// Parametrised single-port data memory with byte strobes, request handshake,
// fixed-latency read pipeline and a backpressured in-order response FIFO.
module data_sram_pipe
   import data_sram_pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wen,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_wen
);

   localparam int unsigned LG_B  = lg_b(DATA_W);
   localparam int unsigned LG_D  = lg_d(DEPTH);
   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned LAT   = clamp_lat(RD_LAT);
   localparam int unsigned CAP   = LAT + 1;
   localparam int unsigned REC_W = DATA_W + RSP_META_W;
   localparam int unsigned CNT_W = $clog2(CAP + 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [CNT_W-1:0]  cnt_q, cnt_d, fifo_cnt;
   logic [LG_D-1:0]   idx;
   logic [REC_W-1:0]  rec_in, push_rec, fifo_head, hold_q, rsp_sel;
   logic              accept, pop, push_vld, misalign, oor, err;

   assign req_ready = rst_n && (cnt_q < CNT_W'(CAP));
   assign accept    = req_valid && req_ready;
   assign idx       = req_addr[LG_B +: LG_D];
   assign misalign  = (req_addr & ADDR_W'(NB - 1)) != '0;
   assign oor       = (req_addr >> (LG_B + LG_D)) != '0;
   assign err       = misalign || oor;

   // Array contents are deliberately not reset so they survive rst_n.
   always_ff @(posedge clk) begin
      if (accept && req_wen && !err) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (req_wstrb[b]) mem_q[idx][8*b +: 8] <= req_wdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      rec_in = '0;
      rec_in[RSP_WEN_POS] = req_wen;
      rec_in[RSP_ERR_POS] = err;
      if (!req_wen && !err) rec_in[RSP_DATA_POS +: DATA_W] = mem_q[idx];
   end

   // The FIFO write itself is the first latency stage, so only LAT-1 extra
   // registers sit between the array and the FIFO.
   if (LAT == 1) begin : g_direct
      assign push_vld = accept;
      assign push_rec = rec_in;
   end else begin : g_pipe
      logic [LAT-2:0]   vld_q;
      logic [REC_W-1:0] rec_q [LAT-1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= '0;
         end else begin
            vld_q[0] <= accept;
            for (int unsigned s = 1; s < LAT - 1; s++) vld_q[s] <= vld_q[s-1];
         end
      end

      always_ff @(posedge clk) begin
         rec_q[0] <= rec_in;
         for (int unsigned s = 1; s < LAT - 1; s++) rec_q[s] <= rec_q[s-1];
      end

      assign push_vld = vld_q[LAT-2];
      assign push_rec = rec_q[LAT-2];
   end

   rsp_fifo #(
      .W     (REC_W),
      .DEPTH (CAP)
   ) u_rsp_fifo (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (push_vld),
      .wdata_i (push_rec),
      .pop_i   (pop),
      .rdata_o (fifo_head),
      .count_o (fifo_cnt)
   );

   assign rsp_valid = fifo_cnt != '0;
   assign pop       = rsp_valid && rsp_ready;
   assign rsp_sel   = rsp_valid ? fifo_head : hold_q;
   assign rsp_rdata = rsp_sel[RSP_DATA_POS +: DATA_W];
   assign rsp_err   = rsp_sel[RSP_ERR_POS];
   assign rsp_wen   = rsp_sel[RSP_WEN_POS];

   always_comb begin
      cnt_d = cnt_q;
      unique case ({accept, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         hold_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (pop) hold_q <= fifo_head;
      end
   end

endmodule

// File: doc/data_sram_pipe.md
Name: data_sram_pipe

Overview:
Parametrised single-port data memory for the core's load/store path. It generalises the fixed 64-bit data_sram with configurable width, depth and read latency. It adds per-byte write strobes, a valid/ready request handshake, a backpressured response channel with an in-order response FIFO, and error reporting for misaligned or out-of-range addresses. It sits between the LSU and its backing storage.

Parameters:
DATA_W, 64, data word width in bits; multiple of 8, power of two.
ADDR_W, 64, byte-address width.
DEPTH, 1024, number of words; power of two.
RD_LAT, 1, cycles from request acceptance to response entering the FIFO; legal range 1..3.
LG_B, log2(DATA_W/8), derived localparam: byte-offset bits.
LG_D, log2(DEPTH), derived localparam: index bits.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset; asynchronous assert, active-low.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_wen  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  write data.
req_wstrb  in  DATA_W/8  byte write enables (bit i -> byte i).
rsp_valid  out  1  response available at FIFO head.
rsp_ready  in  1  consumer takes response.
rsp_rdata  out  DATA_W  read data; 0 for write responses and for errors.
rsp_err  out  1  request was misaligned or out of range.
rsp_wen  out  1  echo of the request type.

Behaviour:
- Accept: a request is accepted on a rising edge where req_valid && req_ready.
- Index: index = req_addr[LG_B +: LG_D].
- Misalignment: the request is misaligned if req_addr[LG_B-1:0] != 0.
- Out of range: the request is out of range if any req_addr bit at or above LG_B+LG_D is set.
- Errored request: either condition sets err. The memory is not read and not written. A response is still produced with rsp_err=1 and rsp_rdata=0.
- Write: committed at the accept edge, only for bytes with req_wstrb[i]=1. A write with wstrb=0 is legal: no change, normal response.
- Read: samples the array at the accept edge. It enters RD_LAT-1 further pipeline stages, then pushes into the response FIFO. With RD_LAT=1 and an empty FIFO, rsp_valid rises the cycle after acceptance.
- Write response: written through the same pipeline, so responses stay strictly in request order.
- Read after write: a read accepted the cycle after a write to the same index returns the new data. There is no same-cycle hazard, since there is one request per cycle.
- Response FIFO: depth RD_LAT+1.
- Credit counter: outstanding = in pipeline + in FIFO, range 0..RD_LAT+1.
  - Increment on accept; decrement on rsp_valid && rsp_ready.
  - Simultaneous increment and decrement: the count is unchanged.
- Ready: req_ready = (outstanding < RD_LAT+1) && rst_n-deasserted. It is combinational from registered state only, with no path from req_valid.
- Full FIFO: req_ready=0 and no request is accepted. A pop in the same cycle does not re-open ready until the next cycle (registered count).
- Empty FIFO: rsp_valid=0. rsp_rdata, rsp_err and rsp_wen hold the last popped values.
- FIFO pointers: wrap modulo FIFO depth. Full and empty are decided from the credit counter and occupancy count, not from pointer equality alone.
- Reset values (asynchronous):
  - req_ready=0 while rst_n=0, then 1 on the first cycle after deassert.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_wen=0.
  - Pipeline valids, FIFO pointers and counters are all 0.
- Array contents are NOT reset and are retained across reset.
- Reset mid-operation: in-flight and queued responses are discarded. Writes already accepted remain in memory.

Decomposition:
- Shared package: derived width localparams (LG_B, LG_D), the response-record field layout (rdata, err, wen), and RD_LAT legal-range constants.
- One natural sub-module: rsp_fifo, a parametrised synchronous FIFO of width DATA_W+2 and depth RD_LAT+1, with count output, async active-low reset, and no data reset.
- The storage array and read pipeline stay in data_sram_pipe.

Test Plan:
1. Basic write and read, defaults: write 22 to 0x10 and 23 to 0x18 (wstrb=0xFF), then read 0x10 and 0x18 -> responses in order: two write acks (rdata=0, err=0), then rdata=22 and rdata=23. Each response appears 1 cycle after acceptance.
2. Byte strobes: write 0x1122334455667788 to 0x20, then write 0xAAAAAAAAAAAAAAAA with wstrb=0x0F, then read 0x20 -> 0x11223344AAAAAAAA.
3. Error cases: read 0x22 -> err=1, rdata=0. Write to 1024*8=0x2000 -> err=1. A following read of 0x0 shows the array unchanged.
4. Backpressure: RD_LAT=2, rsp_ready=0, issue 5 back-to-back reads -> exactly 3 accepted, then req_ready=0. Raise rsp_ready -> responses drain in order, and ready reasserts the cycle after the first pop.
5. Simultaneous push and pop: FIFO at 1 entry, accept and pop in the same cycle -> outstanding unchanged and no response lost.
6. Reset mid-operation: 2 reads outstanding, pulse rst_n low mid-cycle -> rsp_valid drops immediately and no stale response appears afterwards. A re-read after reset returns data written before reset.
